// File: rtl/atpg_vector_sequencer_pkg.sv
// Shared types and constants for the ATPG vector sequencer.
// Default widths match the ISCAS c17 benchmark circuit.
package atpg_pkg;

  localparam int C17_N_IN  = 5;
  localparam int C17_N_OUT = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_APPLY   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // A run is in progress while a vector is being applied, settled or scored.
  function automatic logic is_run_state(state_e s);
    return (s == ST_APPLY) || (s == ST_SETTLE) || (s == ST_CAPTURE);
  endfunction

endpackage

// File: rtl/atpg_vector_sequencer_if.sv
// Host-side bus of the sequencer: vector loading, run control and results.
// The host (loader / fault bench) is the master, the sequencer is the slave.
interface atpg_vector_sequencer_if
  import atpg_pkg::*;
#(
  parameter int N_IN  = C17_N_IN,
  parameter int N_OUT = C17_N_OUT,
  parameter int N_VEC = 16
);
  localparam int AW = (N_VEC > 1) ? $clog2(N_VEC) : 1;
  localparam int CW = $clog2(N_VEC + 1);

  logic             ld_en;
  logic [AW-1:0]    ld_addr;
  logic [N_IN-1:0]  ld_stim;
  logic [N_OUT-1:0] ld_gold;
  logic [CW-1:0]    num_vec;
  logic             stop_on_fail;
  logic             start;
  logic             busy;
  logic             done;
  logic             detected;
  logic [CW-1:0]    fail_count;
  logic [AW-1:0]    first_fail;
  logic [N_OUT-1:0] fail_mask;

  modport master (
    output ld_en, ld_addr, ld_stim, ld_gold, num_vec, stop_on_fail, start,
    input  busy, done, detected, fail_count, first_fail, fail_mask
  );

  modport slave (
    input  ld_en, ld_addr, ld_stim, ld_gold, num_vec, stop_on_fail, start,
    output busy, done, detected, fail_count, first_fail, fail_mask
  );

endinterface

// File: rtl/atpg_vector_sequencer_store.sv
// Vector store: N_VEC entries of {stimulus, golden response}.
// One synchronous write port, asynchronous read by the run index.
// Contents are deliberately not reset so a loaded list survives a reset.
module atpg_vector_store #(
  parameter int N_IN  = 5,
  parameter int N_OUT = 2,
  parameter int N_VEC = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [N_IN-1:0]  wr_stim,
  input  logic [N_OUT-1:0] wr_gold,
  input  logic [AW-1:0]    rd_addr,
  output logic [N_IN-1:0]  rd_stim,
  output logic [N_OUT-1:0] rd_gold
);

  logic [N_IN+N_OUT-1:0] mem_q [N_VEC];

  // Write one entry when the sequencer allows loading.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= {wr_stim, wr_gold};
    end
  end

  assign {rd_stim, rd_gold} = mem_q[rd_addr];

endmodule

// File: rtl/atpg_vector_sequencer.sv
// ATPG vector sequencer: walks the stored vector list, drives each stimulus
// into a combinational CUT, waits SETTLE cycles and scores the response
// against its golden value. Reports detection, failure count, first failing
// index and the OR of all response differences.
module atpg_vector_sequencer
  import atpg_pkg::*;
#(
  parameter int N_IN   = C17_N_IN,
  parameter int N_OUT  = C17_N_OUT,
  parameter int N_VEC  = 16,
  parameter int SETTLE = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  atpg_vector_sequencer_if.slave bus,
  output logic [N_IN-1:0]        cut_in,
  input  logic [N_OUT-1:0]       cut_out
);

  localparam int AW = (N_VEC > 1) ? $clog2(N_VEC) : 1;
  localparam int CW = $clog2(N_VEC + 1);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] NV_MAX      = CW'(N_VEC);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

  state_e           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    nv_q, nv_d;
  logic             sof_q, sof_d;
  logic [N_IN-1:0]  cut_in_q, cut_in_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             detected_q, detected_d;
  logic [CW-1:0]    fail_count_q, fail_count_d;
  logic [AW-1:0]    first_fail_q, first_fail_d;
  logic [N_OUT-1:0] fail_mask_q, fail_mask_d;

  logic             wr_en;
  logic [N_IN-1:0]  rd_stim;
  logic [N_OUT-1:0] rd_gold;
  logic [N_OUT-1:0] diff;
  logic             mismatch;
  logic             last_vec;
  logic [CW-1:0]    nv_clamped;

  // Loading is locked out while a run owns the store.
  assign wr_en      = bus.ld_en && !is_run_state(state_q);
  assign diff       = cut_out ^ rd_gold;
  assign mismatch   = |diff;
  assign last_vec   = ((CW'(idx_q) + CW'(1)) == nv_q);
  assign nv_clamped = (bus.num_vec > NV_MAX) ? NV_MAX : bus.num_vec;

  atpg_vector_store #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT),
    .N_VEC (N_VEC),
    .AW    (AW)
  ) u_store (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (bus.ld_addr),
    .wr_stim (bus.ld_stim),
    .wr_gold (bus.ld_gold),
    .rd_addr (idx_q),
    .rd_stim (rd_stim),
    .rd_gold (rd_gold)
  );

  // Next-state, run bookkeeping and result accumulation.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    nv_d         = nv_q;
    sof_d        = sof_q;
    cut_in_d     = cut_in_q;
    detected_d   = detected_q;
    fail_count_d = fail_count_q;
    first_fail_d = first_fail_q;
    fail_mask_d  = fail_mask_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          idx_d        = '0;
          nv_d         = nv_clamped;
          sof_d        = bus.stop_on_fail;
          detected_d   = 1'b0;
          fail_count_d = '0;
          first_fail_d = '0;
          fail_mask_d  = '0;
          if (nv_clamped == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_APPLY;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_APPLY: begin
        cut_in_d = rd_stim;
        cnt_d    = '0;
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q + SW'(1);
        end
      end
      ST_CAPTURE: begin
        if (mismatch) begin
          fail_count_d = fail_count_q + CW'(1);
          detected_d   = 1'b1;
          fail_mask_d  = fail_mask_q | diff;
          if (!detected_q) begin
            first_fail_d = idx_q;
          end else begin
            first_fail_d = first_fail_q;
          end
        end else begin
          fail_count_d = fail_count_q;
        end
        if (last_vec || (mismatch && sof_q)) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + AW'(1);
          state_d = ST_APPLY;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = is_run_state(state_d);
    done_d = (state_d == ST_DONE);
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      nv_q         <= '0;
      sof_q        <= 1'b0;
      cut_in_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      detected_q   <= 1'b0;
      fail_count_q <= '0;
      first_fail_q <= '0;
      fail_mask_q  <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      nv_q         <= nv_d;
      sof_q        <= sof_d;
      cut_in_q     <= cut_in_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      detected_q   <= detected_d;
      fail_count_q <= fail_count_d;
      first_fail_q <= first_fail_d;
      fail_mask_q  <= fail_mask_d;
    end
  end

  assign cut_in         = cut_in_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.detected   = detected_q;
  assign bus.fail_count = fail_count_q;
  assign bus.first_fail = first_fail_q;
  assign bus.fail_mask  = fail_mask_q;

endmodule
